// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: request/status, BRAM port A and the output stream.
interface bram_stream_reader_if #(
  parameter int dataWidth    = 32,
  parameter int addressWidth = 8
);
  logic                    start;
  logic [addressWidth-1:0] base_addr;
  logic [addressWidth:0]   length;
  logic                    busy;
  logic                    done;
  logic                    enableA;
  logic                    writenableA;
  logic [addressWidth-1:0] addressA;
  logic [dataWidth-1:0]    dataoutA;
  logic [dataWidth-1:0]    m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;

  // Reader side: drives BRAM requests and the stream.
  modport master (
    input  start, base_addr, length, dataoutA, m_ready,
    output busy, done, enableA, writenableA, addressA, m_data, m_valid, m_last
  );

  // Environment side: requester, BRAM and stream consumer.
  modport slave (
    output start, base_addr, length, dataoutA, m_ready,
    input  busy, done, enableA, writenableA, addressA, m_data, m_valid, m_last
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a run of consecutive BRAM words onto a valid/ready stream.
// Reads are credit-limited so that every word in flight through the
// 2-cycle BRAM latency always has a free slot in the output FIFO.
module bram_stream_reader #(
  parameter int dataWidth   = 32,
  parameter int memblocksize = 7424,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  bram_stream_reader_if.master bus
);
  localparam int AW = $clog2(memblocksize / dataWidth);
  localparam int DW = dataWidth;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t         state;
  logic [AW-1:0]  base_r;
  logic [AW:0]    len_r;
  logic [AW:0]    issued;
  logic           busy_r;
  logic           done_r;
  logic           enable_r;
  logic           en_last_r;
  logic [AW-1:0]  address_r;

  // Tag pipe: index 0 is one cycle after issue, index 1 is when data arrives.
  logic [1:0]     pipe_valid;
  logic [1:0]     pipe_last;

  logic [DW-1:0]  fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           valid_r;

  logic           push;
  logic           pop;
  logic [PW:0]    count_next;
  logic [PW+1:0]  outstanding_next;
  logic           credits_ok;
  logic           final_issue;
  logic [AW-1:0]  next_addr;

  // Occupancy bookkeeping and the credit check for the read issued next cycle.
  always_comb begin
    push             = pipe_valid[1];
    pop              = valid_r & bus.m_ready;
    count_next       = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    // Everything that will hold a slot next cycle: this cycle's issue,
    // the tag one stage behind it, and the FIFO after this cycle's push/pop.
    outstanding_next = {{(PW+1){1'b0}}, enable_r} + {{(PW+1){1'b0}}, pipe_valid[0]}
                     + {1'b0, count_next};
    credits_ok       = (outstanding_next < DEPTH_W);
    final_issue      = ((issued + {{AW{1'b0}}, 1'b1}) == len_r);
    next_addr        = base_r + issued[AW-1:0];
  end

  // Control FSM: latches the request, issues credit-limited reads, signals completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_r    <= '0;
      len_r     <= '0;
      issued    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      enable_r  <= 1'b0;
      en_last_r <= 1'b0;
      address_r <= '0;
    end else begin
      done_r    <= 1'b0;
      enable_r  <= 1'b0;
      en_last_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_r <= bus.base_addr;
            len_r  <= bus.length;
            if (bus.length == '0) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
              issued <= '0;
            end else begin
              // Pipeline and FIFO are empty in IDLE, so the first read goes out at once.
              busy_r    <= 1'b1;
              enable_r  <= 1'b1;
              address_r <= bus.base_addr;
              en_last_r <= (bus.length == {{AW{1'b0}}, 1'b1});
              issued    <= {{AW{1'b0}}, 1'b1};
              state     <= (bus.length == {{AW{1'b0}}, 1'b1}) ? DRAIN : READ;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        READ: begin
          if (credits_ok) begin
            enable_r  <= 1'b1;
            address_r <= next_addr;
            en_last_r <= final_issue;
            issued    <= issued + {{AW{1'b0}}, 1'b1};
            if (final_issue) begin
              state <= DRAIN;
            end else begin
              state <= READ;
            end
          end else begin
            state <= READ;
          end
        end
        DRAIN: begin
          if (pop && fifo_last[rd_ptr]) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag pipe tracking the BRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 2'b00;
      pipe_last  <= 2'b00;
    end else begin
      pipe_valid <= {pipe_valid[0], enable_r};
      pipe_last  <= {pipe_last[0], en_last_r};
    end
  end

  // Output FIFO: captures returning words and pops on stream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_r   <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.dataoutA;
        fifo_last[wr_ptr] <= pipe_last[1];
        wr_ptr            <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      count   <= count_next;
      valid_r <= (count_next != '0);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.enableA     = enable_r;
  assign bus.writenableA = 1'b0;
  assign bus.addressA    = address_r;
  assign bus.m_data      = fifo_data[rd_ptr];
  assign bus.m_valid     = valid_r;
  assign bus.m_last      = fifo_last[rd_ptr] & valid_r;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a 2-cycle-latency BRAM model.
module tb_bram_stream_reader;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  bram_stream_reader_if #(.dataWidth(32), .addressWidth(8)) bus ();

  bram_stream_reader #(.dataWidth(32), .memblocksize(7424), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] rd1;
  logic [32:0] sb_q [$];
  logic [7:0]  addr_q [$];

  int  en_cnt, beats, done_cnt, max_out;
  int  first_cyc, last_cyc, done_cyc, start_cyc;
  bit  busy_seen, valid_seen;
  int  rmode;
  int  k;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: two register stages between address and data.
  always @(posedge clk) begin
    rd1          <= bus.enableA ? mem[bus.addressA] : 32'hDEAD_BEEF;
    bus.dataoutA <= rd1;
  end

  // Ready generator: always-ready, or 1,0,0 pattern with a 10-cycle stall.
  initial begin
    k = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        k = 0;
        bus.m_ready = 1'b1;
      end else begin
        bus.m_ready = (k >= 9 && k < 19) ? 1'b0 : ((k % 3) == 0);
        k++;
      end
    end
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented beat with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.enableA) begin
        en_cnt++;
        addr_q.push_back(bus.addressA);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.m_valid) begin
        valid_seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", {bus.m_last, bus.m_data}, 0);
        end else begin
          chk({bus.m_last, bus.m_data} == sb_q[0], "beat", {bus.m_last, bus.m_data}, sb_q[0]);
          if (bus.m_ready) begin
            if (beats == 0) first_cyc = cyc;
            beats++;
            if (bus.m_last) last_cyc = cyc;
            void'(sb_q.pop_front());
          end
        end
      end
      if (en_cnt - beats > max_out) max_out = en_cnt - beats;
    end
  end

  task automatic clear_stats();
    en_cnt = 0; beats = 0; done_cnt = 0; max_out = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    busy_seen = 1'b0; valid_seen = 1'b0;
    addr_q.delete();
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic [8:0] l);
    logic [7:0] a;
    clear_stats();
    for (int i = 0; i < int'(l); i++) begin
      a = b + 8'(i);
      sb_q.push_back({1'(i == int'(l) - 1), mem[a]});
    end
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.length = l;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(done_cnt != 0, "done_timeout", done_cnt, 1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] wrap_exp [4];
    checks = 0; errors = 0; cyc = 0; rmode = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hB000_0000 | 32'(i);
    for (int i = 0; i < 8; i++) mem[16 + i] = 32'hA0 + 32'(i);
    bus.start = 1'b0; bus.base_addr = 8'h00; bus.length = 9'd0;
    clear_stats();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({bus.busy, bus.done, bus.enableA, bus.m_valid, bus.m_last} == 5'b0, "reset_ctrl",
        {bus.busy, bus.done, bus.enableA, bus.m_valid, bus.m_last}, 0);
    chk(bus.addressA == 8'h00, "reset_addr", bus.addressA, 0);
    chk(bus.m_data == 32'h0, "reset_data", bus.m_data, 0);
    rst = 1'b0;

    // Basic read
    start_xfer(8'h10, 9'd8);
    wait_done();
    chk(first_cyc == start_cyc + 4, "first_latency", first_cyc - start_cyc, 4);
    chk(last_cyc == start_cyc + 11, "last_cycle", last_cyc - start_cyc, 11);
    chk(done_cyc == last_cyc + 1, "done_after_last", done_cyc - last_cyc, 1);
    chk(en_cnt == 8, "basic_enables", en_cnt, 8);
    chk(beats == 8, "basic_beats", beats, 8);
    chk(done_cnt == 1, "basic_done_cnt", done_cnt, 1);

    // Backpressure
    rmode = 1;
    start_xfer(8'h10, 9'd8);
    wait_done();
    rmode = 0;
    chk(beats == 8, "bp_beats", beats, 8);
    chk(max_out == 4, "bp_credit_limit", max_out, 4);
    chk(en_cnt == 8, "bp_enables", en_cnt, 8);
    chk(sb_q.size() == 0, "bp_sb_empty", sb_q.size(), 0);

    // Length 0
    start_xfer(8'h30, 9'd0);
    repeat (5) @(posedge clk);
    #1;
    chk(done_cyc == start_cyc + 1, "len0_done", done_cyc - start_cyc, 1);
    chk(done_cnt == 1, "len0_done_cnt", done_cnt, 1);
    chk(en_cnt == 0, "len0_enables", en_cnt, 0);
    chk(valid_seen == 1'b0, "len0_valid", valid_seen, 0);
    chk(busy_seen == 1'b0, "len0_busy", busy_seen, 0);

    // Address wrap
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
    start_xfer(8'hFE, 9'd4);
    wait_done();
    chk(addr_q.size() == 4, "wrap_addr_count", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      chk(addr_q[i] == wrap_exp[i], "wrap_addr", addr_q[i], wrap_exp[i]);
    end
    chk(beats == 4, "wrap_beats", beats, 4);

    // Start while busy
    start_xfer(8'h10, 9'd8);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.base_addr = 8'h40; bus.length = 9'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    repeat (6) @(posedge clk);
    #1;
    chk(beats == 8, "busy_start_beats", beats, 8);
    chk(done_cnt == 1, "busy_start_done", done_cnt, 1);
    chk(en_cnt == 8, "busy_start_enables", en_cnt, 8);

    // Reset mid-operation
    start_xfer(8'h10, 9'd8);
    n = 0;
    while (beats < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(beats >= 3, "rst_wait_timeout", beats, 3);
    #1;
    rst = 1'b1;
    #1;
    chk({bus.m_valid, bus.enableA, bus.busy} == 3'b000, "rst_async_drop",
        {bus.m_valid, bus.enableA, bus.busy}, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    repeat (5) @(posedge clk);
    #1;
    chk(valid_seen == 1'b0, "rst_no_stale", valid_seen, 0);
    chk(en_cnt == 0, "rst_no_reads", en_cnt, 0);
    start_xfer(8'h20, 9'd2);
    wait_done();
    chk(beats == 2, "rst_new_beats", beats, 2);
    chk(sb_q.size() == 0, "rst_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for the team's true-dual-port BRAM wrapper, whose read latency is fixed at 2 cycles.
- On `start`, it streams `length` consecutive words from `base_addr` out of BRAM port A onto a valid/ready stream.
- It tags each in-flight read and absorbs the 2-cycle latency in a 4-entry output FIFO, so that `m_ready` backpressure never loses data.
- It sits between the BRAM instances (weights/activations) and the PE-array load path.

Parameters:
- `dataWidth`, 32: word width; must match the BRAM instance.
- `memblocksize`, 7424: BRAM size in bits; must match the BRAM instance.
- `addressWidth`, `$clog2(memblocksize/dataWidth)` (=8): BRAM address width; derived, never overridden.
- `FIFO_DEPTH`, 4: output buffer entries; fixed at 4, power of two.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  addressWidth  first word address, latched at start.
- `length`  in  addressWidth+1  number of words to read, 0..2^addressWidth, latched at start.
- `busy`  out  1  high from the cycle after an accepted start until the cycle done pulses (inclusive).
- `done`  out  1  one-cycle pulse once the final beat is accepted (or immediately for length 0).
- `enableA`  out  1  BRAM port A enable (read request).
- `writenableA`  out  1  tied 0.
- `addressA`  out  addressWidth  BRAM port A address.
- `dataoutA`  in  dataWidth  BRAM port A read data; valid 2 cycles after `enableA`.
- `m_data`  out  dataWidth  stream data (FIFO head).
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready; a beat transfers when `m_valid` and `m_ready` are both high.
- `m_last`  out  1  high with the final beat of a transfer.

Behaviour:
- Reset (asynchronous): all of the following clear immediately. No partial transfer resumes after reset.
  - State goes to IDLE.
  - `busy`=0, `done`=0, `enableA`=0, `addressA`=0.
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - FIFO is emptied and the in-flight tag pipe is cleared.
- FSM states: IDLE, READ, DRAIN.
  - IDLE + `start`: latch `base_addr`/`length`, set issue counter to 0.
    - `length`=0: remain in IDLE and pulse `done` in the next cycle; no `enableA`, no beats.
    - Otherwise go to READ.
  - READ: issue a read in a cycle iff `credits_ok` is true, where `credits_ok` = (in-flight reads + FIFO occupancy) < `FIFO_DEPTH`.
    - Issuing means `enableA`=1 and `addressA` = (`base_addr` + issued) mod 2^addressWidth, i.e. the address wraps. Then increment issued.
    - When issued reaches `length`, go to DRAIN.
  - DRAIN: no further `enableA`. When the beat with `m_last` is accepted, pulse `done` in the next cycle, then go to IDLE.
  - `start` in READ/DRAIN is ignored: no latch, no effect.
- Tag pipe: a 2-stage shift register carries {valid, last} in parallel with the BRAM latency.
  - A tag entering with `enableA` in cycle T emerges in cycle T+2.
  - In T+2, `dataoutA` is written into the FIFO with its last flag.
  - `last` is set on the read whose issue index is `length`-1.
- FIFO storage and flags are registered. An entry written at the end of cycle T+2 is visible (`m_valid`=1) in T+3. First-beat latency is therefore 4 cycles from the `start` cycle:
  - start in cycle 0;
  - first `enableA` in cycle 1;
  - data at the BRAM port in cycle 3;
  - `m_valid` in cycle 4.
- Simultaneous FIFO write and pop in one cycle is allowed; occupancy is unchanged.
- Because of the credit rule, the FIFO can never overflow. Pop happens only when `m_valid` && `m_ready`.
- Throughput: with `m_ready` held high, one beat per cycle, with no bubbles after the first beat.
- `m_data` and `m_last` are stable while `m_valid`=1 and `m_ready`=0.
- `done` and a new `start` can coincide in the cycle after done. The FSM is already in IDLE, so that start is accepted.
- `busy` stays 0 for length-0 requests.

Test Plan:
- **Basic read:** preload BRAM words 0x10..0x17 with values 0xA0..0xA7; `start`, `base_addr`=0x10, `length`=8, `m_ready`=1.
  - Beats A0..A7 are seen on consecutive cycles; the first appears 4 cycles after start.
  - `m_last` is high only with A7; `done` pulses 1 cycle after the A7 handshake; exactly 8 `enableA` cycles occur.
- **Backpressure:** same transfer, but `m_ready` toggles in the pattern 1,0,0,1,... and is held at 0 for 10 cycles mid-transfer.
  - Output order is A0..A7 with no loss or duplication.
  - `enableA` stops once in-flight + occupancy = 4; `m_data` is stable while stalled.
- **Length 0:** `start`, `length`=0.
  - `done` pulses in the next cycle; `enableA`, `m_valid` and `busy` are never asserted.
- **Address wrap:** `base_addr`=0xFE, `length`=4.
  - `addressA` sequence is 0xFE, 0xFF, 0x00, 0x01; the data matches those words.
- **Start while busy:** assert a second `start` (`base_addr`=0x40) mid-transfer.
  - It is ignored; only the original 8 beats appear and `done` pulses once.
- **Reset mid-operation:** assert `rst` after the 3rd beat, with reads in flight; then release and issue `start`, `base_addr`=0x20, `length`=2.
  - `m_valid`, `enableA` and `busy` drop immediately on `rst`, with no stale beats.
  - The new transfer returns exactly the words at 0x20 and 0x21.
